// File: rtl/snn_learn_ctrl_if.sv
// Handshake and data bundle for the two-layer spiking learning controller.
// master: trial requester / weight loader.  slave: snn_learn_ctrl.
interface snn_learn_ctrl_if;
    logic        start;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        reward_valid;
    logic        reward;
    logic        wload;
    logic [1:0]  wsel;
    logic [4:0]  wdata;
    logic        busy;
    logic        out_valid;
    logic [7:0]  out_sum1;
    logic [7:0]  out_sum2;
    logic [1:0]  out_spike;
    logic        done;
    logic [19:0] weights;

    modport master (
        output start, in_a, in_b, reward_valid, reward,
        output wload, wsel, wdata,
        input  busy, out_valid, out_sum1, out_sum2,
        input  out_spike, done, weights
    );

    modport slave (
        input  start, in_a, in_b, reward_valid, reward,
        input  wload, wsel, wdata,
        output busy, out_valid, out_sum1, out_sum2,
        output out_spike, done, weights
    );
endinterface

// File: rtl/snn_learn_ctrl.sv
// Two-layer spiking network trial controller with reward-modulated learning.
// Ports: clk, rst_n (sync, active-low), bus (snn_learn_ctrl_if.slave):
//   start/in_a/in_b request a trial, reward_valid/reward close it,
//   wload/wsel/wdata write weights in IDLE; busy, out_valid, out_sum1/2,
//   out_spike, done and weights {w4,w3,w2,w1} report status.
// Optional macro SNN_REWARD_TIMEOUT_EN: abandon the reward wait after
//   TIMEOUT cycles; without it the controller waits for reward forever.
module snn_learn_ctrl #(
    parameter logic [7:0] THRESH  = 8'd1,
    parameter int         TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    snn_learn_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_OUT,
        S_WAIT,
        S_UPD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      ina_q, ina_d;
    logic [7:0]      inb_q, inb_d;
    logic [7:0]      sa_q, sa_d;
    logic [7:0]      sb_q, sb_d;
    logic            prea_q, prea_d;
    logic            preb_q, preb_d;
    logic [7:0]      sum1_q, sum1_d;
    logic [7:0]      sum2_q, sum2_d;
    logic [1:0]      spk_q, spk_d;
    logic            rwd_q, rwd_d;
    logic [3:0][4:0] w_q, w_d;

`ifdef SNN_REWARD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    if (TIMEOUT < 1) begin : g_bad_timeout
    end

    // Signed 5-bit weight selects a left shift (w >= 0) or right shift.
    function automatic logic [7:0] syn(input logic [7:0] x,
                                       input logic [4:0] w);
        logic [5:0] mag;
        mag = 6'd0 - {w[4], w};
        if (!w[4]) syn = x << w[3:0];
        else       syn = x >> mag;
    endfunction

    // Saturating +/-1 step; unchanged when the presynaptic neuron is silent.
    function automatic logic [4:0] step(input logic [4:0] w,
                                        input logic pre,
                                        input logic post,
                                        input logic r);
        step = w;
        if (pre) begin
            if (post && r) begin
                if (w != 5'h0F) step = w + 5'd1;
            end else begin
                if (w != 5'h10) step = w - 5'd1;
            end
        end
    endfunction

    logic [7:0] n1, n2, n3, n4;

    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        prea_d  = prea_q;
        preb_d  = preb_q;
        sum1_d  = sum1_q;
        sum2_d  = sum2_q;
        spk_d   = spk_q;
        rwd_d   = rwd_q;
        w_d     = w_q;
        n1      = 8'd0;
        n2      = 8'd0;
        n3      = 8'd0;
        n4      = 8'd0;
`ifdef SNN_REWARD_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.wload) w_d[bus.wsel] = bus.wdata;
                if (bus.start) begin
                    ina_d   = bus.in_a;
                    inb_d   = bus.in_b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sa_d    = {4'd0, ina_q[7:4]} + {4'd0, ina_q[3:0]};
                sb_d    = {4'd0, inb_q[7:4]} + {4'd0, inb_q[3:0]};
                prea_d  = sa_d > THRESH;
                preb_d  = sb_d > THRESH;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                if (prea_q) begin
                    n1 = syn(sa_q, w_q[0]);
                    n3 = syn(sa_q, w_q[1]);
                end
                if (preb_q) begin
                    n2 = syn(sb_q, w_q[2]);
                    n4 = syn(sb_q, w_q[3]);
                end
                sum1_d  = n1 + n2;
                sum2_d  = n3 + n4;
                spk_d   = {sum2_d > THRESH, sum1_d > THRESH};
                state_d = S_OUT;
            end
            S_OUT: begin
`ifdef SNN_REWARD_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.reward_valid) begin
                    rwd_d   = bus.reward;
                    state_d = S_UPD;
                end
`ifdef SNN_REWARD_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_UPD: begin
                w_d[0]  = step(w_q[0], prea_q, spk_q[0], rwd_q);
                w_d[1]  = step(w_q[1], prea_q, spk_q[1], rwd_q);
                w_d[2]  = step(w_q[2], preb_q, spk_q[0], rwd_q);
                w_d[3]  = step(w_q[3], preb_q, spk_q[1], rwd_q);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            prea_q  <= 1'b0;
            preb_q  <= 1'b0;
            sum1_q  <= '0;
            sum2_q  <= '0;
            spk_q   <= '0;
            rwd_q   <= 1'b0;
            w_q     <= '0;
`ifdef SNN_REWARD_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            prea_q  <= prea_d;
            preb_q  <= preb_d;
            sum1_q  <= sum1_d;
            sum2_q  <= sum2_d;
            spk_q   <= spk_d;
            rwd_q   <= rwd_d;
            w_q     <= w_d;
`ifdef SNN_REWARD_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.busy      = state_q != S_IDLE;
    assign bus.out_valid = state_q == S_OUT;
    assign bus.done      = state_q == S_DONE;
    assign bus.out_sum1  = sum1_q;
    assign bus.out_sum2  = sum2_q;
    assign bus.out_spike = spk_q;
    assign bus.weights   = w_q;

endmodule

// File: tb/tb_snn_learn_ctrl.sv
// Randomized self-checking bench for snn_learn_ctrl against an
// arithmetic reference model of trials, learning and weight loads.
module tb_snn_learn_ctrl;
    localparam logic [7:0] TH = 8'd1;
    localparam int         TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_learn_ctrl_if bus();

    snn_learn_ctrl #(.THRESH(TH), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int wm[4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] wexp();
        logic [19:0] v;
        for (int i = 0; i < 4; i++) v[5*i +: 5] = 5'(wm[i]);
        return v;
    endfunction

    function automatic int shf(input int x, input int w);
        if (w >= 0) return (x * (1 << w)) % 256;
        return x / (1 << (-w));
    endfunction

    function automatic int clampw(input int v);
        if (v > 15) return 15;
        if (v < -16) return -16;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.start = 0; bus.in_a = 0; bus.in_b = 0;
        bus.reward_valid = 0; bus.reward = 0;
        bus.wload = 0; bus.wsel = 0; bus.wdata = 0;
    endtask

    task automatic do_reset(input string tg);
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) wm[i] = 0;
        chk({tg, ".busy"}, bus.busy, 0);
        chk({tg, ".ov"}, bus.out_valid, 0);
        chk({tg, ".done"}, bus.done, 0);
        chk({tg, ".w"}, bus.weights, 0);
        chk({tg, ".sums"}, {bus.out_sum1, bus.out_sum2}, 0);
        chk({tg, ".spk"}, bus.out_spike, 0);
    endtask

    task automatic wload_w(input int sel, input int val);
        bus.wload = 1; bus.wsel = 2'(sel); bus.wdata = 5'(val);
        tick();
        bus.wload = 0;
        wm[sel] = val;
        chk("wload", bus.weights, wexp());
    endtask

    task automatic learn(input bit pa, input bit pb, input bit p1,
                         input bit p2, input bit r);
        bit pre, post;
        for (int i = 0; i < 4; i++) begin
            pre  = (i < 2) ? pa : pb;
            post = (i % 2 == 0) ? p1 : p2;
            if (pre) wm[i] = clampw(wm[i] + ((post && r) ? 1 : -1));
        end
    endtask

    task automatic give_reward(input string tg, input bit r, input bit pa,
                               input bit pb, input bit p1, input bit p2);
        bus.reward_valid = 1; bus.reward = r;
        tick();
        bus.reward_valid = 0;
        chk({tg, ".upd_busy"}, bus.busy, 1);
        tick();
        learn(pa, pb, p1, p2, r);
        chk({tg, ".done"}, bus.done, 1);
        chk({tg, ".w"}, bus.weights, wexp());
        tick();
        chk({tg, ".idle"}, {bus.busy, bus.done}, 0);
    endtask

    // mode 0: reward, 1: withheld reward, 2: reset while waiting
    task automatic trial(input string tg, input logic [7:0] a,
                         input logic [7:0] b, input bit r, input int mode,
                         input bit ld, input int sel, input int val);
        int sa, sb, s1, s2, n[4];
        bit pa, pb, p1, p2;
        logic [19:0] wkeep;
        if (ld) begin
            bus.wload = 1; bus.wsel = 2'(sel); bus.wdata = 5'(val);
            wm[sel] = val;
        end
        bus.start = 1; bus.in_a = a; bus.in_b = b;
        tick();
        quiet();
        chk({tg, ".busy"}, bus.busy, 1);
        chk({tg, ".ov_load"}, bus.out_valid, 0);
        sa = int'(a[7:4]) + int'(a[3:0]);
        sb = int'(b[7:4]) + int'(b[3:0]);
        pa = sa > int'(TH);
        pb = sb > int'(TH);
        n[0] = pa ? shf(sa, wm[0]) : 0;
        n[1] = pa ? shf(sa, wm[1]) : 0;
        n[2] = pb ? shf(sb, wm[2]) : 0;
        n[3] = pb ? shf(sb, wm[3]) : 0;
        s1 = (n[0] + n[2]) % 256;
        s2 = (n[1] + n[3]) % 256;
        p1 = s1 > int'(TH);
        p2 = s2 > int'(TH);
        wkeep = wexp();
        // Stray requests while busy must all be ignored.
        bus.start = 1; bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
        bus.wload = 1; bus.wsel = 2'($urandom); bus.wdata = 5'($urandom);
        bus.reward_valid = 1; bus.reward = 1'($urandom);
        tick();
        quiet();
        chk({tg, ".ov_fire"}, bus.out_valid, 0);
        tick();
        chk({tg, ".ov"}, bus.out_valid, 1);
        chk({tg, ".sum1"}, bus.out_sum1, s1);
        chk({tg, ".sum2"}, bus.out_sum2, s2);
        chk({tg, ".spk"}, bus.out_spike, {p2, p1});
        chk({tg, ".w_hold"}, bus.weights, wkeep);
        tick();
        chk({tg, ".ov_off"}, bus.out_valid, 0);
        chk({tg, ".sum_hold"}, {bus.out_sum1, bus.out_sum2}, {s1[7:0], s2[7:0]});
        if (mode == 0) begin
            repeat ($urandom_range(0, 5)) tick();
            give_reward(tg, r, pa, pb, p1, p2);
        end else if (mode == 1) begin
`ifdef SNN_REWARD_TIMEOUT_EN
            repeat (TO - 1) tick();
            chk({tg, ".to_wait"}, {bus.busy, bus.done}, 2'b10);
            tick();
            chk({tg, ".to_done"}, bus.done, 1);
            chk({tg, ".to_w"}, bus.weights, wexp());
            bus.reward_valid = 1; bus.reward = 1;
            tick();
            chk({tg, ".to_idle"}, bus.busy, 0);
            tick();
            bus.reward_valid = 0;
            chk({tg, ".late_w"}, bus.weights, wexp());
            chk({tg, ".late_busy"}, bus.busy, 0);
`else
            repeat (TO + 4) tick();
            chk({tg, ".nowait"}, {bus.busy, bus.done}, 2'b10);
            give_reward(tg, r, pa, pb, p1, p2);
`endif
        end else begin
            repeat ($urandom_range(0, 3)) tick();
            rst_n = 0;
            tick();
            rst_n = 1;
            for (int i = 0; i < 4; i++) wm[i] = 0;
            chk({tg, ".rst_busy"}, bus.busy, 0);
            chk({tg, ".rst_w"}, bus.weights, 0);
            chk({tg, ".rst_sum"}, {bus.out_sum1, bus.out_sum2}, 0);
            chk({tg, ".rst_spk"}, {bus.out_spike, bus.out_valid, bus.done}, 0);
            tick();
            chk({tg, ".rst_stay"}, bus.busy, 0);
        end
    endtask

    initial begin
        quiet();
        do_reset("reset");
        trial("t39", 8'h11, 8'h00, 1, 0, 0, 0, 0);
        chk("t39.w12", bus.weights, {5'd0, 5'd0, 5'd1, 5'd1});
        trial("t40", 8'h11, 8'h00, 1, 0, 0, 0, 0);
        chk("t40.w12", bus.weights, {5'd0, 5'd0, 5'd2, 5'd2});
        do_reset("rst41");
        trial("t41a", 8'h11, 8'h00, 0, 0, 0, 0, 0);
        trial("t41b", 8'h11, 8'h00, 1'($urandom), 0, 0, 0, 0);
        chk("t41.w12", bus.weights, {5'd0, 5'd0, 5'h1E, 5'h1E});
        do_reset("rst42");
        trial("t42", 8'h11, 8'h00, 1, 0, 1, 0, -16);
        chk("t42.w1", bus.weights[4:0], 5'h10);
        wload_w(3, 15);
        wload_w(2, -3);
        trial("t43", 8'h23, 8'h32, 1, 1, 0, 0, 0);
        trial("t44", 8'h45, 8'h21, 1, 2, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0)
                wload_w($urandom_range(0, 3), $urandom_range(0, 31) - 16);
            trial("rnd", 8'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  1'($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3), $urandom_range(0, 31) - 16);
        end
        trial("rnd_rst", 8'($urandom), 8'($urandom), 1, 2, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/snn_learn_ctrl.md
SNN_LEARN_CTRL -- requirements
Module: snn_learn_ctrl

Interface
REQ-001 Parameter THRESH, default 8'd1, firing threshold; a neuron spikes when its 8-bit sum is strictly greater than THRESH.
REQ-002 Parameter TIMEOUT, default 16, number of WAIT_R cycles before the reward wait is abandoned.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request one inference+learning trial; sampled only in IDLE.
REQ-006 in_a  in  8  layer-1 neuron A input, as two 4-bit nibbles; captured on accepted start.
REQ-007 in_b  in  8  layer-1 neuron B input, as two 4-bit nibbles; captured on accepted start.
REQ-008 reward_valid  in  1  reward strobe; sampled only in WAIT_R.
REQ-009 reward  in  1  1 = reward (potentiate), 0 = punish (depress).
REQ-010 wload  in  1  weight write strobe; honoured only in IDLE.
REQ-011 wsel  in  2  weight index for wload (0..3 = w1..w4).
REQ-012 wdata  in  5  signed weight value for wload.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 out_valid  out  1  one-cycle pulse, high in OUTPUT.
REQ-015 out_sum1, out_sum2  out  8 each  layer-2 sums of the current trial, held until the next trial's FIRE.
REQ-016 out_spike  out  2  {post2, post1} layer-2 spike flags, held like out_sum.
REQ-017 done  out  1  one-cycle pulse, high in DONE.
REQ-018 weights  out  20  {w4, w3, w2, w1}, each signed 5-bit.

Function
REQ-019 FSM: IDLE -> LOAD -> FIRE -> OUTPUT -> WAIT_R -> UPDATE -> DONE -> IDLE; each state lasts 1 cycle, except WAIT_R.
REQ-020 IDLE -> LOAD on start=1; start in any other state is ignored.
REQ-021 LOAD: sA = in_a[7:4]+in_a[3:0] and sB = in_b[7:4]+in_b[3:0], both zero-extended to 8 bits; preA = sA>THRESH; preB = sB>THRESH.
REQ-022 Synapse shift S(x,w): x<<w if w>=0, else x>>(-w); 8-bit result, overflow bits discarded; w=-16 gives 0.
REQ-023 FIRE: n1 = preA?S(sA,w1):0, n3 = preA?S(sA,w2):0, n2 = preB?S(sB,w3):0, n4 = preB?S(sB,w4):0.
REQ-024 FIRE (continued): out_sum1 = n1+n2 and out_sum2 = n3+n4, each mod 256; post1 = out_sum1>THRESH; post2 = out_sum2>THRESH.
REQ-025 out_valid is asserted in the 3rd cycle after the edge that accepts start.
REQ-026 WAIT_R: a cycle counter starts at 0; reward_valid=1 latches reward and moves to UPDATE.
REQ-027 WAIT_R timeout: after TIMEOUT cycles with no reward_valid, go to DONE with weights unchanged.
REQ-028 UPDATE, per synapse (pre, post) in w1=(A,1), w2=(A,2), w3=(B,1), w4=(B,2): pre&post -> +1 if reward else -1.
REQ-029 UPDATE (continued): pre&!post -> -1; !pre -> unchanged.
REQ-030 Weight arithmetic saturates to [-16, +15]; it never wraps.
REQ-031 All four weights update in the same UPDATE cycle.
REQ-032 wload in IDLE writes wdata to the weight at wsel on that edge.
REQ-033 wload together with start in IDLE: both take effect, and FIRE uses the loaded weight.
REQ-034 reward_valid outside WAIT_R, and wload outside IDLE, have no effect.

Reset
REQ-035 rst_n=0 at a clock edge, from any state including mid-trial, forces IDLE.
REQ-036 Reset clears all weights, out_sum1, out_sum2, out_spike, the captured sums and the timeout counter to 0, and drives busy, out_valid and done to 0.

Configuration
REQ-037 Macro SNN_REWARD_TIMEOUT_EN: when defined, REQ-027 applies and the TIMEOUT counter is implemented.
REQ-038 Without SNN_REWARD_TIMEOUT_EN, WAIT_R waits indefinitely for reward_valid, and no counter is present.

Verification
REQ-039 Reset, then in_a=8'h11, in_b=8'h00, start, reward=1 -> out_valid with out_sum1=2, out_sum2=2, out_spike=2'b11; afterwards weights w1=w2=+1, w3=w4=0.
REQ-040 Repeat the REQ-039 trial -> out_sum1=4, out_sum2=4; after reward=1, w1=w2=+2.
REQ-041 From reset, in_a=8'h11, reward=0 -> w1=w2=-1; next trial gives out_sum1=1, out_spike=0, and w1=w2=-2 after any reward.
REQ-042 wload w1=-16, in_a=8'h11, reward=1 -> out_sum1=0, and w1 stays at -16 (saturation).
REQ-043 With SNN_REWARD_TIMEOUT_EN, no reward_valid for 16 cycles -> done pulses, weights unchanged, and a late reward_valid is ignored.
REQ-044 Assert rst_n=0 in WAIT_R -> next cycle busy=0 and weights=0; start asserted during busy is ignored.
